// File: rtl/pwm_bank.sv
// pwm_bank: a bank of CHANNELS PWM outputs that share one period counter.
//
// Optional feature macro: PWM_BANK_CENTER_ALIGN_EN
//   When defined, adds the mode_i port and an up/down counting mode for
//   centre-aligned PWM (0 = edge aligned, 1 = centre aligned).
//   When undefined, only edge-aligned counting exists.
//
// Ports:
//   clk_i          - clock; all state changes on the rising edge
//   rst_i          - synchronous active-high reset (wins over load_i and enable_i)
//   enable_i       - counter runs when high and holds when low; pwm_o goes low while held
//   period_i       - period value, captured on load_i
//   duty_i         - per-channel duty values, channel k at [k*CNT_W +: CNT_W]
//   mode_i         - (PWM_BANK_CENTER_ALIGN_EN only) counting mode, captured on load_i
//   load_i         - single-cycle request to capture period/duty/mode
//   pwm_o          - registered PWM outputs, pwm_o[k] = (cnt < duty[k]) one clock later
//   period_start_o - registered one-cycle pulse for counter value 0
//   load_pending_o - high while staged values wait for the next period boundary
//
// Handshake: load_i is a plain single-cycle strobe with no ready; a load
// issued while one is pending simply overwrites the staged values.
module pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic [CNT_W-1:0]          period_i,
    input  logic [CHANNELS*CNT_W-1:0] duty_i,
`ifdef PWM_BANK_CENTER_ALIGN_EN
    input  logic                      mode_i,
`endif
    input  logic                      load_i,
    output logic [CHANNELS-1:0]       pwm_o,
    output logic                      period_start_o,
    output logic                      load_pending_o
);

    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          r_stg_period;
    logic [CNT_W-1:0]          r_act_period;
    logic [CHANNELS*CNT_W-1:0] r_stg_duty;
    logic [CHANNELS*CNT_W-1:0] r_act_duty;
    logic                      r_pending;
    logic [CHANNELS-1:0]       r_pwm;
    logic                      r_period_start;

    logic                      w_boundary;
    logic [CNT_W-1:0]          w_cnt_next;
    logic [CHANNELS-1:0]       w_pwm;

`ifdef PWM_BANK_CENTER_ALIGN_EN
    logic                      r_stg_mode;
    logic                      r_act_mode;
    logic                      r_dir;       // 0 = counting up, 1 = counting down
    logic                      w_dir_next;

    always_comb begin
        w_boundary = 1'b0;
        w_cnt_next = r_cnt;
        w_dir_next = r_dir;
        if (enable_i) begin
            if (!r_act_mode) begin
                if (r_cnt == r_act_period) begin
                    w_boundary = 1'b1;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end else if (!r_dir) begin
                if (r_cnt == r_act_period) begin
                    // Periods 0 and 1 have no downward leg: the top is the boundary.
                    if (r_act_period <= CNT_W'(1)) begin
                        w_boundary = 1'b1;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                        w_dir_next = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end else begin
                // Leaving cnt 1 on the way down closes the cycle; 0 starts the next.
                if (r_cnt <= CNT_W'(1)) begin
                    w_boundary = 1'b1;
                    w_cnt_next = '0;
                    w_dir_next = 1'b0;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
        end
    end
`else
    always_comb begin
        w_boundary = 1'b0;
        w_cnt_next = r_cnt;
        if (enable_i) begin
            if (r_cnt == r_act_period) begin
                w_boundary = 1'b1;
                w_cnt_next = '0;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end
`endif

    // Unsigned full-width compare: duty 0 never fires, duty > period always does.
    always_comb begin
        w_pwm = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_pwm[k] = enable_i && (r_cnt < r_act_duty[k*CNT_W +: CNT_W]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt          <= '0;
            r_stg_period   <= '0;
            r_act_period   <= '0;
            r_stg_duty     <= '0;
            r_act_duty     <= '0;
            r_pending      <= 1'b0;
            r_pwm          <= '0;
            r_period_start <= 1'b0;
`ifdef PWM_BANK_CENTER_ALIGN_EN
            r_stg_mode     <= 1'b0;
            r_act_mode     <= 1'b0;
            r_dir          <= 1'b0;
`endif
        end else begin
            r_cnt          <= w_cnt_next;
            r_pwm          <= w_pwm;
            r_period_start <= enable_i && (r_cnt == '0);
`ifdef PWM_BANK_CENTER_ALIGN_EN
            r_dir          <= w_dir_next;
`endif
            if (w_boundary) begin
                // A load on the boundary edge bypasses staging entirely.
                if (load_i) begin
                    r_act_period <= period_i;
                    r_act_duty   <= duty_i;
`ifdef PWM_BANK_CENTER_ALIGN_EN
                    r_act_mode   <= mode_i;
`endif
                end else if (r_pending) begin
                    r_act_period <= r_stg_period;
                    r_act_duty   <= r_stg_duty;
`ifdef PWM_BANK_CENTER_ALIGN_EN
                    r_act_mode   <= r_stg_mode;
`endif
                end
                r_pending <= 1'b0;
            end else if (load_i) begin
                r_stg_period <= period_i;
                r_stg_duty   <= duty_i;
`ifdef PWM_BANK_CENTER_ALIGN_EN
                r_stg_mode   <= mode_i;
`endif
                r_pending    <= 1'b1;
            end
        end
    end

    assign pwm_o          = r_pwm;
    assign period_start_o = r_period_start;
    assign load_pending_o = r_pending;

endmodule
